// File: rtl/link_rx_fifo_if.sv
// Handshake bundle between the link slave, the rx FIFO and its consumer.
// Ports: in_valid/in_data/in_ready (link side), out_valid/out_data/out_ready (consumer side).
interface link_rx_fifo_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );
endinterface

// File: rtl/link_rx_fifo.sv
// Receive FIFO behind the link slave, with fixed-length frame checksumming.
// Ports: i_clk, i_rst (sync, active-low), bus (slave modport), o_count,
// o_frame_done (1-cycle pulse), o_frame_sum, o_overflow (sticky).
module link_rx_fifo #(
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  link_rx_fifo_if.slave bus,
  output logic [CW-1:0] o_count,
  output logic          o_frame_done,
  output logic [7:0]    o_frame_sum,
  output logic          o_overflow
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [0:0]    r_state;
  logic [7:0]    r_acc;
  logic [7:0]    r_byte_cnt;
  logic [7:0]    r_frame_sum;
  logic          r_frame_done;
  logic          r_overflow;

  logic          w_full;
  logic          w_wr;
  logic          w_rd;
  logic          w_last;
  logic [7:0]    w_acc_base;
  logic [7:0]    w_sum;

  assign w_full = (r_count == CW'(DEPTH));

  // Held low through reset so nothing is accepted before the
  // registered state has been cleared.
  assign bus.in_ready  = i_rst & ~w_full;
  assign bus.out_valid = i_rst & (r_count != '0);
  assign bus.out_data  = r_mem[r_rd_ptr];

  assign w_wr = bus.in_valid & bus.in_ready;
  assign w_rd = bus.out_valid & bus.out_ready;

  // IDLE means a fresh frame: the accumulator contributes nothing.
  assign w_acc_base = (r_state == S_IDLE) ? 8'h00 : r_acc;
  assign w_sum      = w_acc_base + bus.in_data;
  assign w_last     = (r_byte_cnt == 8'(FRAME_LEN - 1));

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_overflow <= 1'b0;
    end else if (bus.in_valid && !bus.in_ready) begin
      r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_byte_cnt   <= '0;
      r_frame_sum  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_wr) begin
        if (w_last) begin
          r_frame_sum  <= w_sum;
          r_frame_done <= 1'b1;
          r_acc        <= '0;
          r_byte_cnt   <= '0;
          r_state      <= S_IDLE;
        end else begin
          r_acc        <= w_sum;
          r_byte_cnt   <= r_byte_cnt + 1'b1;
          r_state      <= S_ACCUM;
        end
      end
    end
  end

  assign o_count      = r_count;
  assign o_frame_done = r_frame_done;
  assign o_frame_sum  = r_frame_sum;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_link_rx_fifo.sv
// Directed bench for link_rx_fifo (DEPTH=4, FRAME_LEN=4).
// Inputs change 1ns after each rising edge; outputs are checked there.
module tb_link_rx_fifo;

  logic       clk;
  logic       rst;
  logic [2:0] count;
  logic       frame_done;
  logic [7:0] frame_sum;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  link_rx_fifo_if bus ();

  link_rx_fifo #(
    .DEPTH     (4),
    .FRAME_LEN (4)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .bus          (bus.slave),
    .o_count      (count),
    .o_frame_done (frame_done),
    .o_frame_sum  (frame_sum),
    .o_overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_q [$];
  logic [7:0] b;

  initial begin
    rst           = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h77;
    bus.out_ready = 1'b0;

    // Reset held for 3 cycles with a strobe present.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_count", count, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_frame_done", frame_done, 0);
    end
    chk("rst_frame_sum", frame_sum, 0);

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Single frame, no reads.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h10;
    tick();
    chk("w1_count", count, 1);
    chk("w1_out_valid", bus.out_valid, 1);
    chk("w1_out_data", bus.out_data, 8'h10);
    bus.in_data = 8'h20;
    tick();
    bus.in_data = 8'h30;
    tick();
    chk("w3_frame_done", frame_done, 0);
    bus.in_data = 8'h40;
    tick();
    chk("w4_count", count, 4);
    chk("w4_in_ready", bus.in_ready, 0);
    chk("w4_frame_done", frame_done, 1);
    chk("w4_frame_sum", frame_sum, 8'hA0);
    bus.in_valid = 1'b0;
    tick();
    chk("f1_done_clear", frame_done, 0);
    chk("f1_sum_hold", frame_sum, 8'hA0);

    // Drain in order.
    exp_q = '{8'h10, 8'h20, 8'h30, 8'h40};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b = exp_q.pop_front();
      chk("drain1_data", bus.out_data, b);
      tick();
    end
    chk("drain1_count", count, 0);
    chk("drain1_out_valid", bus.out_valid, 0);

    // Checksum wraps mod 256; reads run alongside.
    exp_q = '{8'hFF, 8'h01, 8'h80, 8'h80};
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = exp_q[i];
      tick();
      chk("wrap_count", count, 1);
      chk("wrap_done", frame_done, (i == 3) ? 1 : 0);
    end
    chk("wrap_sum", frame_sum, 8'h00);
    bus.in_valid = 1'b0;
    chk("wrap_last_data", bus.out_data, 8'h80);
    tick();
    chk("wrap_done_clear", frame_done, 0);
    chk("wrap_empty", count, 0);
    bus.out_ready = 1'b0;

    // Fill, then overflow.
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.in_data = 8'(i);
      tick();
    end
    chk("fill_sum", frame_sum, 8'h0A);
    chk("fill_done", frame_done, 1);
    chk("pre_ovf_flag", overflow, 0);
    bus.in_data = 8'h55;
    tick();
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 4);
    chk("ovf_done", frame_done, 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("ovf_sticky", overflow, 1);
    chk("ovf_drain_count", count, 2);

    // Simultaneous read/write at count 2; pointers wrap.
    exp_q = '{8'h03, 8'h04};
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_data = 8'hA0 + 8'(i);
      exp_q.push_back(bus.in_data);
      b = exp_q.pop_front();
      chk("rw_data", bus.out_data, b);
      tick();
      chk("rw_count", count, 2);
      chk("rw_done", frame_done, (i == 3 || i == 7) ? 1 : 0);
      if (i == 3) chk("rw_sum0", frame_sum, 8'h86);
      if (i == 7) chk("rw_sum1", frame_sum, 8'h96);
    end
    bus.in_valid = 1'b0;
    chk("rw_tail0", bus.out_data, 8'hA8);
    tick();
    chk("rw_tail1", bus.out_data, 8'hA9);
    tick();
    chk("rw_empty", count, 0);
    bus.out_ready = 1'b0;

    // Clean reset clears the sticky flag and sum.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rst2_overflow", overflow, 0);
    chk("rst2_sum", frame_sum, 0);

    // Reset mid-frame.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    tick();
    bus.in_data = 8'h02;
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_done", frame_done, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 3; i <= 6; i++) begin
      bus.in_data = 8'(i);
      tick();
      chk("mid_done", frame_done, (i == 6) ? 1 : 0);
    end
    chk("mid_sum", frame_sum, 8'h12);
    chk("mid_count", count, 4);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 3; i <= 6; i++) begin
      chk("mid_data", bus.out_data, 8'(i));
      tick();
    end
    chk("mid_empty", count, 0);
    chk("mid_done_once", frame_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/link_rx_fifo.md
# link_rx_fifo

Receive-side buffer that sits directly downstream of the link slave FSM. It accepts each byte the slave latches from the req/ack link, stores it in a small FIFO, and presents it to the consumer over a valid/ready interface. It also groups accepted bytes into fixed-length frames, producing a per-frame 8-bit checksum and a one-cycle `frame_done` pulse.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `FRAME_LEN`, default 4: bytes per frame; at least 1, at most 255.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-low reset.
- `in_valid` input 1: one-cycle strobe from the slave side; a byte is on `in_data`.
- `in_data` input 8: byte from the slave, i.e. its `last_byte`.
- `in_ready` output 1: FIFO can accept a byte this cycle.
- `out_valid` output 1: head-of-FIFO byte is available.
- `out_data` output 8: head-of-FIFO byte (show-ahead).
- `out_ready` input 1: consumer takes the head byte this cycle.
- `count` output $clog2(DEPTH)+1: current occupancy.
- `frame_done` output 1: one-cycle pulse after the last byte of a frame is accepted.
- `frame_sum` output 8: checksum of the most recently completed frame.
- `overflow` output 1: sticky flag; a byte was offered while the FIFO was full.

## Operation
- Write: `wr = in_valid & in_ready`. The byte goes to `mem[wr_ptr]` and `wr_ptr` increments modulo DEPTH.
- `in_ready = !full`, with `full = (count == DEPTH)`. A read in the same cycle does not raise `in_ready` when full (no pass-through).
- Read: `rd = out_valid & out_ready`. `rd_ptr` increments modulo DEPTH. `out_data = mem[rd_ptr]`; it is undefined when `out_valid = 0`.
- `out_valid = (count != 0)`, derived from registered state.
- Occupancy:
  - write only: +1
  - read only: −1
  - both: unchanged
  - neither: unchanged
- Pointers are log2(DEPTH) bits and wrap naturally. Full and empty are distinguished by `count` only.
- Overflow: if `in_valid = 1` while `in_ready = 0`, the byte is dropped and `overflow` is set. `overflow` clears only on reset.
- Frame FSM states:
  - IDLE: `byte_cnt = 0`, `acc = 0`.
  - ACCUM: `acc = acc + byte` (mod 256) and `byte_cnt + 1` on each write.
  - On the write that makes `byte_cnt == FRAME_LEN`:
    - `frame_sum <= acc + in_data` (mod 256);
    - `frame_done <= 1`;
    - `byte_cnt <= 0`;
    - `acc <= 0`;
    - state returns to IDLE.
- With FRAME_LEN = 1, every write completes a frame.
- A write in the same cycle `frame_done` is high starts the next frame normally.
- Dropped (overflow) bytes never count toward a frame or a checksum.
- Frame accounting follows writes only; reads do not affect it.

## Timing
- Reset (`rst = 0` at a rising edge) clears `wr_ptr`, `rd_ptr`, `count`, `acc`, `byte_cnt`, `frame_sum`, `frame_done` and `overflow` to 0. State goes to IDLE.
- While `rst = 0`, `in_ready` is forced to 0; `out_valid` is 0.
- After reset, the first cycle with `rst = 1` has `in_ready = 1`.
- Latency: a byte accepted at edge N has `out_valid = 1` and `out_data` equal to that byte from edge N onward (one cycle after the strobe is sampled).
- `frame_done` is high for exactly the cycle following the edge that accepted the frame's last byte. `frame_sum` updates on that same edge and holds until the next frame completes.
- Reset asserted mid-frame or with the FIFO non-empty discards all contents and partial frame state. No `frame_done` is produced for the partial frame.
- Throughput: one write and one read per cycle, sustained.

## Test plan
- Reset: hold `rst = 0` for 3 cycles with `in_valid = 1` → `in_ready = 0`, `count = 0`, `out_valid = 0`, `overflow = 0`, `frame_done` never pulses.
- Single frame: write 0x10, 0x20, 0x30, 0x40 on consecutive cycles with `out_ready = 0` → `count` reaches 4, `in_ready = 0`, `frame_done` pulses once one cycle after the 0x40 write, `frame_sum = 0xA0`. Then drain with `out_ready = 1` → reads 0x10, 0x20, 0x30, 0x40 in order, `count` returns to 0.
- Checksum wrap: frame 0xFF, 0x01, 0x80, 0x80 → `frame_sum = 0x00`, one `frame_done` pulse.
- Overflow: fill to 4 with `out_ready = 0`, then strobe 0x55 → byte dropped, `overflow = 1` and stays 1, `count = 4`. The next frame's sum excludes 0x55.
- Simultaneous read/write with `count = 2`: write 0xAA and read in the same cycle → `count` stays 2. Pointers wrap correctly across 10 such cycles with data order preserved.
- Reset mid-frame: write 0x01, 0x02, assert `rst = 0` for 1 cycle, release, then write 0x03, 0x04, 0x05, 0x06 → a single `frame_done` with `frame_sum = 0x12`; the FIFO contains only the last 4 bytes.
